cmac_usplus_tx_sender: RTL and testbench

- Downstream neighbour of the packet emitter; drives the CMAC TX AXI-Stream.
- Captures one frame of 512-bit beats into an internal frame buffer.
- On a kick, replays the buffered frame to the CMAC with correct tkeep/tlast and reports cmac_busy/cmac_done back to the emitter.
- Holds one frame at a time; drops malformed or oversized frames and counts them.

---
 rtl/cmac_usplus_tx_sender_pkg.sv | 11 +
 rtl/cmac_usplus_tx_sender_if.sv | 11 +
 rtl/cmac_usplus_tx_sender_ram.sv | 23 ++
 rtl/cmac_usplus_tx_sender.sv | 110 +++++++++++
 tb/tb_cmac_usplus_tx_sender.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cmac_usplus_tx_sender_pkg.sv
// cmac_tx_pkg: shared types and beat-math helpers for the CMAC TX sender
package cmac_tx_pkg;
  localparam int BEAT_BYTES = 64;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DROP, DONE} state_e;
  function automatic logic [63:0] rem_to_keep(input logic [5:0] rem);
    return rem == 6'd0 ? '1 : (64'd1 << rem) - 64'd1;
  endfunction
  function automatic logic [31:0] bytes_to_words(input logic [31:0] bytes);
    return (bytes + 32'(BEAT_BYTES - 1)) / 32'(BEAT_BYTES);
  endfunction
endpackage

// File: rtl/cmac_usplus_tx_sender_if.sv
// cmac_usplus_tx_sender_if: AXI-Stream TX bundle towards the CMAC
interface cmac_usplus_tx_sender_if;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid;
  logic         tlast;
  logic         tuser;
  logic         tready;
  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cmac_usplus_tx_sender_ram.sv
// cmac_tx_frame_ram: simple dual-port frame buffer with registered, enabled read
module cmac_tx_frame_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [WIDTH-1:0]      rd
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  // array write, no reset on storage
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // read register only moves when a new beat is requested, so it doubles as the held output beat
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/cmac_usplus_tx_sender.sv
// cmac_usplus_tx_sender: buffers one frame and replays it on the CMAC TX AXI-Stream
module cmac_usplus_tx_sender
  import cmac_tx_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BYTES_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [511:0]           din_data,
  input  logic                   din_valid,
  input  logic                   din_kick,
  input  logic [BYTES_WIDTH-1:0] din_bytes,
  output logic                   cmac_busy,
  output logic                   cmac_done,
  cmac_usplus_tx_sender_if.master tx,
  output logic [31:0]            tx_frames,
  output logic [15:0]            drop_frames
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  state_e state, state_nx;
  logic [PW-1:0] wr_ptr, wr_cnt, words, beat_idx, nxt_idx;
  logic [5:0] rem;
  logic ovf, ovf_eff, full, wr_en, kick, drop, hs, load_beat, nxt_last, valid_q, last_q;
  logic [63:0] keep_q;
  logic [511:0] rd_data;
  assign full      = wr_ptr == PW'(DEPTH);
  assign wr_en     = state == IDLE && din_valid && !full;
  assign wr_cnt    = wr_ptr + PW'(wr_en);
  assign ovf_eff   = ovf || (state == IDLE && din_valid && full);
  assign kick      = state == IDLE && din_kick;
  assign drop      = din_bytes == '0 || ovf_eff || bytes_to_words(32'(din_bytes)) != 32'(wr_cnt);
  assign hs        = valid_q && tx.tready;
  assign load_beat = state == LOAD || (state == SEND && hs && !last_q);
  assign nxt_idx   = state == LOAD ? '0 : beat_idx + PW'(1);
  assign nxt_last  = nxt_idx == words - PW'(1);
  cmac_tx_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(512)) u_ram (
    .clk(clk), .reset(reset),
    .we(wr_en), .wa(wr_ptr[ADDR_WIDTH-1:0]), .wd(din_data),
    .re(load_beat), .ra(nxt_idx[ADDR_WIDTH-1:0]), .rd(rd_data)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next-state decode; a kick is only honoured in IDLE
  always_comb
    state_nx = state == IDLE ? (din_kick ? (drop ? DROP : LOAD) : IDLE) :
               state == LOAD ? SEND :
               state == SEND ? (hs && last_q ? DONE : SEND) :
               state == DROP ? DONE : IDLE;
  // status outputs decoded from the registered state
  always_comb begin
    cmac_busy = state inside {LOAD, SEND, DROP};
    cmac_done = state == DONE;
  end
  // capture pointer and sticky overflow, both recycled once the frame retires
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      ovf    <= 1'b0;
    end else if (state == DONE) begin
      wr_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_cnt;
      ovf    <= ovf_eff;
    end
  // frame length latched at the kick for the replay
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      words <= '0;
      rem   <= '0;
    end else if (kick) begin
      words <= wr_cnt;
      rem   <= din_bytes[5:0];
    end
  // beat sideband registered alongside the RAM read so it tracks the held data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      keep_q   <= '0;
      beat_idx <= '0;
    end else if (load_beat) begin
      valid_q  <= 1'b1;
      last_q   <= nxt_last;
      keep_q   <= nxt_last ? rem_to_keep(rem) : '1;
      beat_idx <= nxt_idx;
    end else if (hs) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      keep_q   <= '0;
    end
  // sent-frame counter wraps, drop counter saturates
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_frames   <= '0;
      drop_frames <= '0;
    end else begin
      if (hs && last_q) tx_frames <= tx_frames + 32'd1;
      if (kick && drop && drop_frames != 16'hFFFF) drop_frames <= drop_frames + 16'd1;
    end
  assign tx.tdata  = rd_data;
  assign tx.tkeep  = keep_q;
  assign tx.tvalid = valid_q;
  assign tx.tlast  = last_q;
  assign tx.tuser  = 1'b0;
endmodule

// File: tb/tb_cmac_usplus_tx_sender.sv
// tb_cmac_usplus_tx_sender: frame-level checks of the TX sender against a beat-list model
module tb_cmac_usplus_tx_sender;
  typedef struct {
    int sel;
    int nbytes;
    int nwrite;
    int mode;
    int drop;
    int overlap;
    int hold;
  } frame_t;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, tready = 1'b0;
  logic [511:0] din_data = '0;
  logic din_valid = 1'b0, din_kick = 1'b0;
  logic [13:0] din_bytes = '0;
  logic b_valid, s_valid, b_kick, s_kick;
  logic b_busy, b_done, s_busy, s_done;
  logic [31:0] b_txf, s_txf;
  logic [15:0] b_drf, s_drf;
  logic m_tvalid, m_tlast, m_busy, m_done;
  logic [511:0] m_tdata;
  logic [63:0] m_tkeep;
  logic [31:0] m_txf;
  logic [15:0] m_drf;
  int n_chk = 0, n_fail = 0;
  int exp_tx[2] = '{0, 0};
  int exp_dr[2] = '{0, 0};
  int pat[6] = '{1, 0, 0, 1, 0, 1};
  frame_t tbl[11];
  frame_t rf;
  cmac_usplus_tx_sender_if tx();
  cmac_usplus_tx_sender_if txs();
  always #5 clk = ~clk;
  assign b_valid = din_valid & ~sel;
  assign s_valid = din_valid & sel;
  assign b_kick  = din_kick & ~sel;
  assign s_kick  = din_kick & sel;
  assign tx.tready  = tready;
  assign txs.tready = tready;
  assign m_tvalid = sel ? txs.tvalid : tx.tvalid;
  assign m_tlast  = sel ? txs.tlast : tx.tlast;
  assign m_tdata  = sel ? txs.tdata : tx.tdata;
  assign m_tkeep  = sel ? txs.tkeep : tx.tkeep;
  assign m_busy   = sel ? s_busy : b_busy;
  assign m_done   = sel ? s_done : b_done;
  assign m_txf    = sel ? s_txf : b_txf;
  assign m_drf    = sel ? s_drf : b_drf;
  cmac_usplus_tx_sender #(.ADDR_WIDTH(8), .BYTES_WIDTH(14)) dut (
    .clk(clk), .reset(reset), .din_data(din_data), .din_valid(b_valid), .din_kick(b_kick),
    .din_bytes(din_bytes), .cmac_busy(b_busy), .cmac_done(b_done), .tx(tx),
    .tx_frames(b_txf), .drop_frames(b_drf)
  );
  cmac_usplus_tx_sender #(.ADDR_WIDTH(2), .BYTES_WIDTH(14)) dut_s (
    .clk(clk), .reset(reset), .din_data(din_data), .din_valid(s_valid), .din_kick(s_kick),
    .din_bytes(din_bytes), .cmac_busy(s_busy), .cmac_done(s_done), .tx(txs),
    .tx_frames(s_txf), .drop_frames(s_drf)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_frame(input frame_t f);
    logic [511:0] q[$];
    logic [511:0] d;
    logic [63:0] kp;
    int words, idx, cyc, bub, ov;
    sel = f.sel != 0;
    ov = (f.overlap != 0 && f.nwrite > 0) ? 1 : 0;
    for (int i = 0; i < f.nwrite; i++) begin
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      q.push_back(d);
    end
    for (int i = 0; i < f.nwrite - ov; i++) begin
      din_valid = 1'b1;
      din_data = q[i];
      tick;
    end
    din_valid = ov != 0;
    if (ov != 0) din_data = q[f.nwrite-1];
    din_kick = 1'b1;
    din_bytes = 14'(f.nbytes);
    tick;
    din_valid = 1'b0;
    din_kick = f.hold != 0;
    chk("busy_after_kick", m_busy, 1);
    chk("tvalid_in_first_busy", m_tvalid, 0);
    if (f.drop != 0) begin
      exp_dr[sel]++;
      tick;
      chk("drop_done", m_done, 1);
      chk("drop_busy_clear", m_busy, 0);
      chk("drop_tvalid", m_tvalid, 0);
      chk("drop_frames", m_drf, exp_dr[sel]);
      tick;
      chk("done_pulse_one_cycle", m_done, 0);
      return;
    end
    words = (f.nbytes + 63) / 64;
    tick;
    chk("tvalid_two_after_kick", m_tvalid, 1);
    idx = 0;
    cyc = 0;
    bub = 0;
    while (idx < words && cyc < 1500) begin
      tready = f.mode == 0 ? 1'b1 : f.mode == 1 ? pat[cyc % 6] != 0 : $urandom_range(0, 1) != 0;
      if (!m_tvalid) bub++;
      else begin
        kp = (idx == words - 1 && f.nbytes % 64 != 0) ? (64'd1 << (f.nbytes % 64)) - 64'd1 : '1;
        chk("tdata", m_tdata, q[idx]);
        chk("tkeep", m_tkeep, kp);
        chk("tlast", m_tlast, idx == words - 1);
        if (tready) idx++;
      end
      tick;
      cyc++;
    end
    tready = 1'b0;
    chk("beats_sent", idx, words);
    chk("no_bubble", bub, 0);
    if (f.mode == 0) chk("back_to_back_cycles", cyc, words);
    exp_tx[sel]++;
    chk("done_after_last", m_done, 1);
    chk("busy_clear_after_last", m_busy, 0);
    chk("tvalid_after_last", m_tvalid, 0);
    chk("tx_frames", m_txf, exp_tx[sel]);
    tick;
    chk("done_pulse_one_cycle", m_done, 0);
    if (f.hold != 0) begin
      tick;
      chk("held_kick_redecoded", m_busy, 1);
      din_kick = 1'b0;
      exp_dr[sel]++;
      tick;
      chk("held_kick_drop_done", m_done, 1);
      chk("held_kick_drop_count", m_drf, exp_dr[sel]);
      tick;
    end
  endtask
  initial begin
    tbl = '{
      '{0, 60, 1, 0, 0, 0, 0},
      '{0, 150, 3, 1, 0, 0, 0},
      '{0, 128, 2, 0, 0, 0, 0},
      '{0, 200, 2, 0, 1, 0, 0},
      '{0, 60, 1, 0, 0, 0, 0},
      '{0, 0, 0, 0, 1, 0, 0},
      '{0, 130, 3, 2, 0, 1, 0},
      '{0, 64, 1, 1, 0, 0, 1},
      '{1, 320, 5, 0, 1, 0, 0},
      '{1, 256, 4, 0, 0, 0, 0},
      '{0, 16383, 256, 2, 0, 0, 0}
    };
    tick;
    tick;
    chk("rst_tvalid", tx.tvalid, 0);
    chk("rst_tkeep", tx.tkeep, 0);
    chk("rst_tlast", tx.tlast, 0);
    chk("rst_tdata", tx.tdata, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_tx_frames", b_txf, 0);
    chk("rst_drop_frames", b_drf, 0);
    chk("rst_small_tvalid", txs.tvalid, 0);
    #3 reset = 1'b1;
    tick;
    foreach (tbl[i]) run_frame(tbl[i]);
    for (int i = 0; i < 15; i++) begin
      rf.sel = 0;
      rf.nwrite = $urandom_range(1, 6);
      rf.nbytes = (rf.nwrite - 1) * 64 + $urandom_range(1, 64);
      if ($urandom_range(0, 3) == 0) rf.nbytes += 64 * $urandom_range(1, 2);
      rf.mode = $urandom_range(0, 2);
      rf.overlap = $urandom_range(0, 1);
      rf.hold = 0;
      rf.drop = (rf.nbytes == 0 || rf.nwrite > 256 || (rf.nbytes + 63) / 64 != rf.nwrite) ? 1 : 0;
      run_frame(rf);
    end
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din_data = {16{32'hDEAD_BEEF}};
      tick;
    end
    din_valid = 1'b0;
    din_kick = 1'b1;
    din_bytes = 14'd256;
    tick;
    din_kick = 1'b0;
    tick;
    tick;
    chk("stalled_before_reset", tx.tvalid, 1);
    #2 reset = 1'b0;
    #1;
    chk("reset_tvalid_async", tx.tvalid, 0);
    chk("reset_busy_async", b_busy, 0);
    chk("reset_tx_frames", b_txf, 0);
    chk("reset_drop_frames", b_drf, 0);
    exp_tx = '{0, 0};
    exp_dr = '{0, 0};
    tick;
    tick;
    #3 reset = 1'b1;
    tick;
    rf = '{0, 60, 1, 0, 0, 0, 0};
    run_frame(rf);
    chk("tuser_zero", tx.tuser, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
